mmio_axil_arbiter: RTL and testbench
====================================

Name: mmio_axil_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter placed in front of mmio_subsystem. It shares the MMIO slave port between master 0 (CPU data port) and master 1 (debug/DMA).
- One transaction is in flight at a time: either a write (AW+W then B) or a read (AR then R).
- Round-robin fairness between the masters. Zero added data-path latency once a grant is issued.

Parameters:
- ADDR_WIDTH, 16, AXI address width (matches the MMIO port).
- DATA_WIDTH, 32, AXI data width; wstrb width is DATA_WIDTH/8.

Ports:
- aclk  input  1  system clock.
- arst  input  1  reset.
- S_AXI_awaddr/awprot/awvalid  input  [1:0][ADDR_WIDTH-1:0]/[1:0][2:0]/[1:0]  upstream AW, index = master.
- S_AXI_awready  output  [1:0]  upstream AW ready.
- S_AXI_wdata/wstrb/wvalid  input  [1:0][DATA_WIDTH-1:0]/[1:0][DATA_WIDTH/8-1:0]/[1:0]  upstream W.
- S_AXI_wready  output  [1:0]  upstream W ready.
- S_AXI_bresp/bvalid  output  [1:0][1:0]/[1:0]  upstream B.
- S_AXI_bready  input  [1:0]  upstream B ready.
- S_AXI_araddr/arprot/arvalid  input  [1:0][ADDR_WIDTH-1:0]/[1:0][2:0]/[1:0]  upstream AR.
- S_AXI_arready  output  [1:0]  upstream AR ready.
- S_AXI_rdata/rresp/rvalid  output  [1:0][DATA_WIDTH-1:0]/[1:0][1:0]/[1:0]  upstream R.
- S_AXI_rready  input  [1:0]  upstream R ready.
- M_AXI_aw*/w*/ar*/bready/rready  output  as above, single copy  downstream request channels to mmio_subsystem.
- M_AXI_awready/wready/arready/b*/r*  input  as above, single copy  downstream responses.
- busy  output  1  a transaction is owned.
- grant_id  output  1  owning master; holds the last owner when idle.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - All valid and ready outputs are 0.
  - All data, addr, resp and prot outputs are 0.
  - busy=0, grant_id=0.
  - Round-robin pointer favours master 0.
- State machine states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA.
- Request definition: req[i] = awvalid[i] | arvalid[i].
- IDLE:
  - If any req is set, grant the requester with priority. The master != last owner wins a tie.
  - Within the granted master, write wins if awvalid and arvalid are both high.
  - Register grant_id. Go to WR or RD_ADDR next cycle; busy=1 from that cycle.
  - The grant decision takes 1 cycle. No upstream ready is asserted in IDLE.
- WR:
  - Mux the owner's AW and W channels to M_AXI. Owner awready/wready = M_AXI ready; the non-owner sees 0.
  - Sticky aw_done/w_done flags are set on each handshake. After a handshake, the corresponding M_AXI valid is forced to 0.
  - When both flags are set (including the same-cycle case), go to WR_RESP.
- WR_RESP:
  - Route M_AXI_bvalid/bresp to the owner; M_AXI_bready = owner bready.
  - On the B handshake go to IDLE, clear the flags and update the RR pointer to the owner.
- RD_ADDR: mux the owner's AR channel; on the AR handshake go to RD_DATA.
- RD_DATA:
  - Route rdata/rresp/rvalid to the owner; M_AXI_rready = owner rready.
  - On the R handshake go to IDLE and update the RR pointer.
- Non-owner isolation: all non-owner upstream outputs are 0 at all times. Downstream valids are 0 outside the owning states.
- Back-pressure: the arbiter holds state indefinitely while the slave stalls ready or the master stalls bready/rready. There is no timeout.
- Response pass-through: bresp and rresp pass through unmodified (OKAY, SLVERR and DECERR are all forwarded).
- Ownership lock: ownership is held until the response handshake. Other requests wait; no preemption.
- Reset mid-transaction: all state is cleared immediately and any outstanding transaction is dropped. Downstream valids fall asynchronously.
- Back-to-back transactions: minimum one IDLE cycle between transactions.

Test Plan:
- Read, M0 only: M0 arvalid with araddr=0x0010; slave arready after 2 cycles, rdata=0xDEADBEEF, rresp=0 -> M0 rvalid with 0xDEADBEEF; M1 sees all 0; busy low again 1 cycle after the R handshake.
- Write, skewed channels: M1 write addr=0x0104, wdata=0x0000000F, wstrb=4'hF; slave wready 1 cycle before awready -> single downstream W beat and single AW beat; M1 bresp=0; grant_id=1.
- Simultaneous writes then reads: after reset, M0 and M1 both request 4 times continuously -> grant order 0,1,0,1,0,1,0,1; no master starved.
- Same-master write/read collision: M0 asserts awvalid and arvalid together -> write is serviced first, read on the next grant (or M1 first if it is also requesting).
- Stalls and error response: slave returns bresp=2'b10 while M0 holds bready=0 for 5 cycles -> M0 bvalid with bresp=2'b10 held stable for 5 cycles; no new grant issued.
- Reset mid-transaction: assert arst during RD_DATA -> all valid/ready outputs and busy=0 the same cycle; after release, M1's pending request is granted first only if M0 is idle.

Source files
------------

// File: rtl/mmio_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mmio_axil_arbiter
// Purpose  : Two-master to one-slave AXI4-Lite arbiter in front of the MMIO
//            subsystem. One transaction in flight, round-robin between masters,
//            combinational pass-through once a grant is held.
// Revision : 1.0  initial release
// ============================================================================
module mmio_axil_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    aclk,
  input  logic                                    arst,
  // Upstream (index = master)
  input  logic [1:0][ADDR_WIDTH-1:0]              S_AXI_awaddr,
  input  logic [1:0][2:0]                         S_AXI_awprot,
  input  logic [1:0]                              S_AXI_awvalid,
  output logic [1:0]                              S_AXI_awready,
  input  logic [1:0][DATA_WIDTH-1:0]              S_AXI_wdata,
  input  logic [1:0][DATA_WIDTH/8-1:0]            S_AXI_wstrb,
  input  logic [1:0]                              S_AXI_wvalid,
  output logic [1:0]                              S_AXI_wready,
  output logic [1:0][1:0]                         S_AXI_bresp,
  output logic [1:0]                              S_AXI_bvalid,
  input  logic [1:0]                              S_AXI_bready,
  input  logic [1:0][ADDR_WIDTH-1:0]              S_AXI_araddr,
  input  logic [1:0][2:0]                         S_AXI_arprot,
  input  logic [1:0]                              S_AXI_arvalid,
  output logic [1:0]                              S_AXI_arready,
  output logic [1:0][DATA_WIDTH-1:0]              S_AXI_rdata,
  output logic [1:0][1:0]                         S_AXI_rresp,
  output logic [1:0]                              S_AXI_rvalid,
  input  logic [1:0]                              S_AXI_rready,
  // Downstream
  output logic [ADDR_WIDTH-1:0]                   M_AXI_awaddr,
  output logic [2:0]                              M_AXI_awprot,
  output logic                                    M_AXI_awvalid,
  input  logic                                    M_AXI_awready,
  output logic [DATA_WIDTH-1:0]                   M_AXI_wdata,
  output logic [DATA_WIDTH/8-1:0]                 M_AXI_wstrb,
  output logic                                    M_AXI_wvalid,
  input  logic                                    M_AXI_wready,
  input  logic [1:0]                              M_AXI_bresp,
  input  logic                                    M_AXI_bvalid,
  output logic                                    M_AXI_bready,
  output logic [ADDR_WIDTH-1:0]                   M_AXI_araddr,
  output logic [2:0]                              M_AXI_arprot,
  output logic                                    M_AXI_arvalid,
  input  logic                                    M_AXI_arready,
  input  logic [DATA_WIDTH-1:0]                   M_AXI_rdata,
  input  logic [1:0]                              M_AXI_rresp,
  input  logic                                    M_AXI_rvalid,
  output logic                                    M_AXI_rready,
  // Status
  output logic                                    busy,
  output logic                                    grant_id
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_owner;     // current / most recent owner
  logic       r_last;      // round-robin pointer: last master to complete
  logic       r_aw_done;
  logic       r_w_done;

  logic [1:0] w_req;
  logic       w_grant_id;
  logic       w_grant_wr;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_r_hs;

  // Request vector and round-robin pick; on a tie the master that did not
  // own the bus last wins. Within a master, a pending write beats a read.
  always_comb begin
    w_req      = S_AXI_awvalid | S_AXI_arvalid;
    w_grant_id = (&w_req) ? ~r_last : w_req[1];
    w_grant_wr = S_AXI_awvalid[w_grant_id];
  end

  // Next-state and channel muxing; everything not owned stays at zero.
  always_comb begin
    w_next        = r_state;
    S_AXI_awready = '0;
    S_AXI_wready  = '0;
    S_AXI_bresp   = '0;
    S_AXI_bvalid  = '0;
    S_AXI_arready = '0;
    S_AXI_rdata   = '0;
    S_AXI_rresp   = '0;
    S_AXI_rvalid  = '0;
    M_AXI_awaddr  = '0;
    M_AXI_awprot  = '0;
    M_AXI_awvalid = 1'b0;
    M_AXI_wdata   = '0;
    M_AXI_wstrb   = '0;
    M_AXI_wvalid  = 1'b0;
    M_AXI_bready  = 1'b0;
    M_AXI_araddr  = '0;
    M_AXI_arprot  = '0;
    M_AXI_arvalid = 1'b0;
    M_AXI_rready  = 1'b0;
    w_aw_hs       = 1'b0;
    w_w_hs        = 1'b0;
    w_b_hs        = 1'b0;
    w_r_hs        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_next = w_grant_wr ? ST_WR : ST_RD_ADDR;
        end
      end
      ST_WR: begin
        // Each channel is suppressed once its beat has been accepted so the
        // slave never sees a duplicate AW or W.
        M_AXI_awaddr           = S_AXI_awaddr[r_owner];
        M_AXI_awprot           = S_AXI_awprot[r_owner];
        M_AXI_awvalid          = S_AXI_awvalid[r_owner] & ~r_aw_done;
        S_AXI_awready[r_owner] = M_AXI_awready & ~r_aw_done;
        M_AXI_wdata            = S_AXI_wdata[r_owner];
        M_AXI_wstrb            = S_AXI_wstrb[r_owner];
        M_AXI_wvalid           = S_AXI_wvalid[r_owner] & ~r_w_done;
        S_AXI_wready[r_owner]  = M_AXI_wready & ~r_w_done;
        w_aw_hs                = M_AXI_awvalid & M_AXI_awready;
        w_w_hs                 = M_AXI_wvalid & M_AXI_wready;
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_next = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        S_AXI_bvalid[r_owner] = M_AXI_bvalid;
        S_AXI_bresp[r_owner]  = M_AXI_bresp;
        M_AXI_bready          = S_AXI_bready[r_owner];
        w_b_hs                = M_AXI_bvalid & M_AXI_bready;
        if (w_b_hs) begin
          w_next = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        M_AXI_araddr           = S_AXI_araddr[r_owner];
        M_AXI_arprot           = S_AXI_arprot[r_owner];
        M_AXI_arvalid          = S_AXI_arvalid[r_owner];
        S_AXI_arready[r_owner] = M_AXI_arready;
        if (M_AXI_arvalid && M_AXI_arready) begin
          w_next = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        S_AXI_rvalid[r_owner] = M_AXI_rvalid;
        S_AXI_rdata[r_owner]  = M_AXI_rdata;
        S_AXI_rresp[r_owner]  = M_AXI_rresp;
        M_AXI_rready          = S_AXI_rready[r_owner];
        w_r_hs                = M_AXI_rvalid & M_AXI_rready;
        if (w_r_hs) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, ownership, round-robin pointer and sticky write-channel flags.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_state   <= ST_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;   // master 0 wins the first tie
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          if (|w_req) begin
            r_owner <= w_grant_id;
          end
        end
        ST_WR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        ST_WR_RESP: begin
          if (w_b_hs) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_last    <= r_owner;
          end
        end
        ST_RD_DATA: begin
          if (w_r_hs) r_last <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // Status outputs.
  always_comb begin
    busy     = (r_state != ST_IDLE);
    grant_id = r_owner;
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_axil_arbiter
// Purpose  : Directed self-checking bench for mmio_axil_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_axil_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic                     aclk = 1'b0;
  logic                     arst = 1'b1;
  logic [1:0][AW-1:0]       s_awaddr = '0;
  logic [1:0][2:0]          s_awprot = '0;
  logic [1:0]               s_awvalid = '0;
  logic [1:0]               s_awready;
  logic [1:0][DW-1:0]       s_wdata = '0;
  logic [1:0][DW/8-1:0]     s_wstrb = '0;
  logic [1:0]               s_wvalid = '0;
  logic [1:0]               s_wready;
  logic [1:0][1:0]          s_bresp;
  logic [1:0]               s_bvalid;
  logic [1:0]               s_bready = '0;
  logic [1:0][AW-1:0]       s_araddr = '0;
  logic [1:0][2:0]          s_arprot = '0;
  logic [1:0]               s_arvalid = '0;
  logic [1:0]               s_arready;
  logic [1:0][DW-1:0]       s_rdata;
  logic [1:0][1:0]          s_rresp;
  logic [1:0]               s_rvalid;
  logic [1:0]               s_rready = '0;
  logic [AW-1:0]            m_awaddr;
  logic [2:0]               m_awprot;
  logic                     m_awvalid;
  logic                     m_awready = 1'b0;
  logic [DW-1:0]            m_wdata;
  logic [DW/8-1:0]          m_wstrb;
  logic                     m_wvalid;
  logic                     m_wready = 1'b0;
  logic [1:0]               m_bresp = '0;
  logic                     m_bvalid = 1'b0;
  logic                     m_bready;
  logic [AW-1:0]            m_araddr;
  logic [2:0]               m_arprot;
  logic                     m_arvalid;
  logic                     m_arready = 1'b0;
  logic [DW-1:0]            m_rdata = '0;
  logic [1:0]               m_rresp = '0;
  logic                     m_rvalid = 1'b0;
  logic                     m_rready;
  logic                     busy;
  logic                     grant_id;

  int n_tests = 0;
  int n_fail  = 0;
  int aw_cnt  = 0;
  int w_cnt   = 0;

  mmio_axil_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .arst(arst),
    .S_AXI_awaddr(s_awaddr), .S_AXI_awprot(s_awprot), .S_AXI_awvalid(s_awvalid),
    .S_AXI_awready(s_awready),
    .S_AXI_wdata(s_wdata), .S_AXI_wstrb(s_wstrb), .S_AXI_wvalid(s_wvalid),
    .S_AXI_wready(s_wready),
    .S_AXI_bresp(s_bresp), .S_AXI_bvalid(s_bvalid), .S_AXI_bready(s_bready),
    .S_AXI_araddr(s_araddr), .S_AXI_arprot(s_arprot), .S_AXI_arvalid(s_arvalid),
    .S_AXI_arready(s_arready),
    .S_AXI_rdata(s_rdata), .S_AXI_rresp(s_rresp), .S_AXI_rvalid(s_rvalid),
    .S_AXI_rready(s_rready),
    .M_AXI_awaddr(m_awaddr), .M_AXI_awprot(m_awprot), .M_AXI_awvalid(m_awvalid),
    .M_AXI_awready(m_awready),
    .M_AXI_wdata(m_wdata), .M_AXI_wstrb(m_wstrb), .M_AXI_wvalid(m_wvalid),
    .M_AXI_wready(m_wready),
    .M_AXI_bresp(m_bresp), .M_AXI_bvalid(m_bvalid), .M_AXI_bready(m_bready),
    .M_AXI_araddr(m_araddr), .M_AXI_arprot(m_arprot), .M_AXI_arvalid(m_arvalid),
    .M_AXI_arready(m_arready),
    .M_AXI_rdata(m_rdata), .M_AXI_rresp(m_rresp), .M_AXI_rvalid(m_rvalid),
    .M_AXI_rready(m_rready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 aclk = ~aclk;

  // Count downstream AW and W beats seen by the slave.
  always @(posedge aclk) begin
    if (!arst) begin
      if (m_awvalid && m_awready) aw_cnt <= aw_cnt + 1;
      if (m_wvalid && m_wready)   w_cnt  <= w_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    // ---------------- reset values ----------------
    s_araddr[0] = 16'h0010;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("rst_s_readies", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 0);
    chk("rst_m_araddr", m_araddr, 0);
    arst = 1'b0;
    tick();

    // ---------------- read, M0 only ----------------
    s_arvalid[0] = 1'b1;
    #1;
    chk("idle_no_arready", s_arready, 2'b00);
    tick();                                   // RD_ADDR
    chk("rd_busy", busy, 1);
    chk("rd_grant", grant_id, 0);
    chk("rd_m_arvalid", m_arvalid, 1);
    chk("rd_m_araddr", m_araddr, 16'h0010);
    tick();
    tick();
    m_arready = 1'b1;
    #1;
    chk("rd_s_arready", s_arready, 2'b01);
    tick();                                   // RD_DATA
    s_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00; s_rready = 2'b01;
    #1;
    chk("rd_s_rvalid", s_rvalid, 2'b01);
    chk("rd_s_rdata0", s_rdata[0], 32'hDEADBEEF);
    chk("rd_s_rdata1", s_rdata[1], 0);
    chk("rd_m_rready", m_rready, 1);
    tick();                                   // IDLE
    m_rvalid = 1'b0; s_rready = '0;
    chk("rd_busy_low", busy, 0);

    // ---------------- write, M1, W before AW ----------------
    s_awvalid[1] = 1'b1; s_awaddr[1] = 16'h0104;
    s_wvalid[1] = 1'b1; s_wdata[1] = 32'h0000000F; s_wstrb[1] = 4'hF;
    tick();                                   // WR
    chk("wr_grant", grant_id, 1);
    chk("wr_m_valids", {m_awvalid, m_wvalid}, 2'b11);
    chk("wr_m_awaddr", m_awaddr, 16'h0104);
    chk("wr_m_wstrb", m_wstrb, 4'hF);
    m_wready = 1'b1;
    #1;
    chk("wr_s_wready", s_wready, 2'b10);
    tick();                                   // W accepted; master and slave keep asserting
    chk("wr_w_suppressed", m_wvalid, 0);
    chk("wr_aw_pending", m_awvalid, 1);
    m_awready = 1'b1;
    #1;
    chk("wr_s_awready", s_awready, 2'b10);
    tick();                                   // WR_RESP
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    chk("wr_aw_beats", aw_cnt, 1);
    chk("wr_w_beats", w_cnt, 1);
    m_bvalid = 1'b1; m_bresp = 2'b00; s_bready = 2'b10;
    #1;
    chk("wr_s_bvalid", s_bvalid, 2'b10);
    chk("wr_s_bresp1", s_bresp[1], 2'b00);
    chk("wr_m_bready", m_bready, 1);
    tick();                                   // IDLE
    m_bvalid = 1'b0; s_bready = '0;
    chk("wr_busy_low", busy, 0);

    // ---------------- round robin, both masters reading ----------------
    s_arvalid = 2'b11; s_rready = 2'b11; m_arready = 1'b1;
    m_rvalid = 1'b1; m_rdata = 32'h12340000;
    for (int k = 0; k < 8; k++) begin
      tick();                                 // RD_ADDR
      chk("rr_grant", grant_id, k[0]);
      tick();                                 // RD_DATA
      chk("rr_rvalid_isolated", s_rvalid, k[0] ? 2'b10 : 2'b01);
      tick();                                 // IDLE
    end
    s_arvalid = '0; s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0;
    #1;
    chk("rr_idle", busy, 0);

    // ---------------- M0 write+read together, then error stall ----------------
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_arvalid[0] = 1'b1;
    s_awaddr[0] = 16'h0020; s_wdata[0] = 32'hA5A5A5A5; s_wstrb[0] = 4'h3;
    tick();                                   // WR
    chk("col_grant", grant_id, 0);
    chk("col_write_first", {m_awvalid, m_arvalid}, 2'b10);
    m_awready = 1'b1; m_wready = 1'b1;
    tick();                                   // WR_RESP
    s_awvalid = '0; s_wvalid = '0; m_awready = 1'b0; m_wready = 1'b0;
    s_arvalid[1] = 1'b1;
    m_bvalid = 1'b1; m_bresp = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_bvalid", s_bvalid, 2'b01);
      chk("stall_bresp", s_bresp[0], 2'b10);
      chk("stall_no_regrant", {grant_id, m_arvalid, busy}, 3'b001);
      tick();
    end
    s_bready[0] = 1'b1;
    tick();                                   // IDLE, M0 was last owner
    m_bvalid = 1'b0; s_bready = '0;
    tick();                                   // RD_ADDR; tie goes to M1
    chk("col_m1_next", grant_id, 1);
    chk("col_m1_araddr", m_arvalid, 1);
    m_arready = 1'b1;
    tick();                                   // RD_DATA, slave not yet responding
    m_arready = 1'b0; s_arvalid[1] = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h55AA55AA;
    s_rready = 2'b00;

    // ---------------- reset during RD_DATA ----------------
    #1;
    chk("mid_busy", busy, 1);
    arst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rvalid", s_rvalid, 2'b00);
    chk("mid_rst_m", {m_rready, m_arvalid, m_awvalid, m_wvalid}, 0);
    chk("mid_rst_grant", grant_id, 0);
    m_rvalid = 1'b0;
    s_arvalid = 2'b11;                        // both pending after release
    #1;
    arst = 1'b0;
    tick();
    chk("post_rst_m0_first", grant_id, 0);
    m_arready = 1'b1;
    tick();                                   // RD_DATA
    m_arready = 1'b0; s_arvalid[0] = 1'b0;
    m_rvalid = 1'b1; s_rready = 2'b01;
    tick();                                   // IDLE
    m_rvalid = 1'b0; s_rready = '0;
    tick();                                   // M1 pending, M0 idle
    chk("post_rst_m1", {busy, grant_id}, 2'b11);
    s_arvalid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
